// File: rtl/dds_phase_accumulator_pkg.sv
// Shared DDS constants and accumulator state encodings.
// Imported by the phase accumulator and its tuning-word shadow sub-module.
package dds_phase_accumulator_pkg;

   localparam int ROM_PHASE_BIT     = 10;
   localparam int ROM_AMPLITUDE_BIT = 12;
   localparam int ROM_PHASE_MAX_VAL = (1 << ROM_PHASE_BIT) - 1;
   localparam int DDS_ACC_BIT       = 32;

   typedef enum logic [0:0] {
      DDS_ACC_IDLE    = 1'b0,
      DDS_ACC_PENDING = 1'b1
   } dds_acc_state_t;

endpackage

// File: rtl/dds_ftw_shadow.sv
// Tuning-word intake: holds a deferred word until the accumulator wraps,
// and tells the accumulator when and which word to adopt.
module dds_ftw_shadow
   import dds_phase_accumulator_pkg::*;
#(
   parameter int ACC_BIT = DDS_ACC_BIT
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               carry,
   input  logic               ftw_valid,
   input  logic               apply_at_wrap,
   input  logic [ACC_BIT-1:0] ftw_data,
   input  logic [ACC_BIT-1:0] ftw_active,
   output logic               ftw_ready,
   output logic               apply,
   output logic [ACC_BIT-1:0] apply_word
);

   dds_acc_state_t     state_r;
   logic [ACC_BIT-1:0] shadow_r;
   logic               accept_s;
   logic               active_zero_s;
   logic               defer_s;
   logic               release_s;

   // Handshake decode; a zero active word would never wrap, so deferral is refused.
   always_comb begin
      ftw_ready     = (state_r == DDS_ACC_IDLE);
      accept_s      = ftw_valid & ftw_ready;
      active_zero_s = (ftw_active == {ACC_BIT{1'b0}});
      defer_s       = accept_s & apply_at_wrap & ~clear & ~active_zero_s;
      release_s     = clear | carry | active_zero_s;
   end

   // Select the word to apply this edge, if any.
   always_comb begin
      apply      = 1'b0;
      apply_word = ftw_data;
      case (state_r)
         DDS_ACC_IDLE: begin
            if (accept_s & ~defer_s) begin
               apply      = 1'b1;
               apply_word = ftw_data;
            end else begin
               apply      = 1'b0;
               apply_word = ftw_data;
            end
         end
         DDS_ACC_PENDING: begin
            if (release_s) begin
               apply      = 1'b1;
               apply_word = shadow_r;
            end else begin
               apply      = 1'b0;
               apply_word = shadow_r;
            end
         end
         default: begin
            apply      = 1'b0;
            apply_word = ftw_data;
         end
      endcase
   end

   // Shadow register and pending-state machine.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= DDS_ACC_IDLE;
         shadow_r <= {ACC_BIT{1'b0}};
      end else begin
         case (state_r)
            DDS_ACC_IDLE: begin
               if (defer_s) begin
                  shadow_r <= ftw_data;
                  state_r  <= DDS_ACC_PENDING;
               end else begin
                  state_r  <= DDS_ACC_IDLE;
               end
            end
            DDS_ACC_PENDING: begin
               if (release_s) begin
                  state_r <= DDS_ACC_IDLE;
               end else begin
                  state_r <= DDS_ACC_PENDING;
               end
            end
            default: begin
               state_r <= DDS_ACC_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/dds_phase_accumulator.sv
// Numerically controlled oscillator: accumulates the active tuning word and
// presents the truncated, offset phase to the waveform ROMs.
module dds_phase_accumulator
   import dds_phase_accumulator_pkg::*;
#(
   parameter int ACC_BIT   = DDS_ACC_BIT,
   parameter int PHASE_BIT = ROM_PHASE_BIT
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 clear,
   input  logic [ACC_BIT-1:0]   ftw_data,
   input  logic                 ftw_valid,
   output logic                 ftw_ready,
   input  logic                 apply_at_wrap,
   input  logic [PHASE_BIT-1:0] phase_offset,
   output logic [PHASE_BIT-1:0] phase,
   output logic                 wrap,
   output logic [ACC_BIT-1:0]   ftw_active
);

   logic [ACC_BIT-1:0]   acc_r;
   logic [ACC_BIT-1:0]   ftw_active_r;
   logic [PHASE_BIT-1:0] phase_r;
   logic                 wrap_r;
   logic [ACC_BIT:0]     sum_s;
   logic [ACC_BIT-1:0]   acc_next_s;
   logic                 carry_s;
   logic [PHASE_BIT-1:0] phase_next_s;
   logic                 apply_s;
   logic [ACC_BIT-1:0]   apply_word_s;

   dds_ftw_shadow #(
      .ACC_BIT (ACC_BIT)
   ) u_shadow (
      .clk           (clk),
      .rst_n         (rst_n),
      .clear         (clear),
      .carry         (carry_s),
      .ftw_valid     (ftw_valid),
      .apply_at_wrap (apply_at_wrap),
      .ftw_data      (ftw_data),
      .ftw_active    (ftw_active_r),
      .ftw_ready     (ftw_ready),
      .apply         (apply_s),
      .apply_word    (apply_word_s)
   );

   // Next accumulator value and carry; clear wins over enable.
   always_comb begin
      sum_s = {1'b0, acc_r} + {1'b0, ftw_active_r};
      if (clear) begin
         acc_next_s = {ACC_BIT{1'b0}};
         carry_s    = 1'b0;
      end else if (enable) begin
         acc_next_s = sum_s[ACC_BIT-1:0];
         carry_s    = sum_s[ACC_BIT];
      end else begin
         acc_next_s = acc_r;
         carry_s    = 1'b0;
      end
      // Phase is taken from the next accumulator value so it lines up with acc.
      phase_next_s = acc_next_s[ACC_BIT-1 -: PHASE_BIT] + phase_offset;
   end

   // Accumulator, phase, wrap pulse and active tuning word registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r        <= {ACC_BIT{1'b0}};
         phase_r      <= {PHASE_BIT{1'b0}};
         wrap_r       <= 1'b0;
         ftw_active_r <= {ACC_BIT{1'b0}};
      end else begin
         acc_r   <= acc_next_s;
         phase_r <= phase_next_s;
         wrap_r  <= carry_s;
         if (apply_s) begin
            ftw_active_r <= apply_word_s;
         end else begin
            ftw_active_r <= ftw_active_r;
         end
      end
   end

   assign phase      = phase_r;
   assign wrap       = wrap_r;
   assign ftw_active = ftw_active_r;

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// Directed, table-driven bench for dds_phase_accumulator (ACC_BIT=32, PHASE_BIT=10).
module tb_dds_phase_accumulator;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        clear;
   logic [31:0] ftw_data;
   logic        ftw_valid;
   logic        ftw_ready;
   logic        apply_at_wrap;
   logic [9:0]  phase_offset;
   logic [9:0]  phase;
   logic        wrap;
   logic [31:0] ftw_active;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic        en;
      logic        clr;
      logic        vld;
      logic        aaw;
      logic [31:0] data;
      logic [9:0]  off;
      logic [9:0]  e_phase;
      logic        e_wrap;
      logic        e_ready;
      logic [31:0] e_fa;
   } vec_t;

   vec_t tbl [22];

   dds_phase_accumulator #(
      .ACC_BIT   (32),
      .PHASE_BIT (10)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .clear         (clear),
      .ftw_data      (ftw_data),
      .ftw_valid     (ftw_valid),
      .ftw_ready     (ftw_ready),
      .apply_at_wrap (apply_at_wrap),
      .phase_offset  (phase_offset),
      .phase         (phase),
      .wrap          (wrap),
      .ftw_active    (ftw_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [9:0] e_ph, input logic e_w,
                          input logic e_r, input logic [31:0] e_fa);
      chk({tag, " phase"}, {22'd0, phase}, {22'd0, e_ph});
      chk({tag, " wrap"}, {31'd0, wrap}, {31'd0, e_w});
      chk({tag, " ready"}, {31'd0, ftw_ready}, {31'd0, e_r});
      chk({tag, " ftw_active"}, ftw_active, e_fa);
   endtask

   task automatic drive(input logic en, input logic clr, input logic vld, input logic aaw,
                        input logic [31:0] data, input logic [9:0] off);
      enable        = en;
      clear         = clr;
      ftw_valid     = vld;
      apply_at_wrap = aaw;
      ftw_data      = data;
      phase_offset  = off;
   endtask

   initial begin
      //          en    clr   vld   aaw   data          off    phase  wrap  ready fa
      tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0040_0000, 10'h000, 10'h000, 1'b0, 1'b1, 32'h0040_0000};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 10'h000, 10'h001, 1'b0, 1'b1, 32'h0040_0000};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 10'h000, 10'h002, 1'b0, 1'b1, 32'h0040_0000};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 10'h000, 10'h002, 1'b0, 1'b1, 32'h0040_0000};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 10'h3FF, 10'h001, 1'b0, 1'b1, 32'h0040_0000};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 10'h000, 10'h003, 1'b0, 1'b1, 32'h0040_0000};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 10'h005, 10'h005, 1'b0, 1'b1, 32'h0040_0000};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 10'h000, 10'h001, 1'b0, 1'b1, 32'h0040_0000};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 10'h000, 10'h002, 1'b0, 1'b1, 32'h8000_0000};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 10'h000, 10'h202, 1'b0, 1'b1, 32'h8000_0000};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 10'h000, 10'h002, 1'b1, 1'b1, 32'h8000_0000};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 10'h000, 10'h202, 1'b0, 1'b1, 32'h8000_0000};
      tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 10'h000, 10'h002, 1'b1, 1'b1, 32'h8000_0000};
      tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 10'h000, 10'h000, 1'b0, 1'b1, 32'h8000_0000};
      tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 10'h000, 10'h200, 1'b0, 1'b1, 32'h8000_0000};
      tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 10'h000, 10'h000, 1'b1, 1'b1, 32'h8000_0000};
      tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 10'h3FF, 10'h3FF, 1'b0, 1'b1, 32'h0000_0000};
      tbl[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0040_0000, 10'h3FF, 10'h3FF, 1'b0, 1'b1, 32'h0040_0000};
      tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 10'h3FF, 10'h000, 1'b0, 1'b1, 32'h0040_0000};
      tbl[19] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 10'h000, 10'h000, 1'b0, 1'b1, 32'h0000_0000};
      tbl[20] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0010_0000, 10'h000, 10'h000, 1'b0, 1'b1, 32'h0010_0000};
      tbl[21] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 10'h000, 10'h000, 1'b0, 1'b1, 32'h0010_0000};

      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 10'h000);
      #2;
      chk_all("reset", 10'h000, 1'b0, 1'b1, 32'h0000_0000);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 22; i++) begin
         drive(tbl[i].en, tbl[i].clr, tbl[i].vld, tbl[i].aaw, tbl[i].data, tbl[i].off);
         tick();
         chk_all($sformatf("row%0d", i), tbl[i].e_phase, tbl[i].e_wrap, tbl[i].e_ready, tbl[i].e_fa);
      end

      // Full revolution at one phase step per cycle, then run on to phase 100.
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0040_0000, 10'h000);
      tick();
      chk_all("ramp start", 10'h000, 1'b0, 1'b1, 32'h0040_0000);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 10'h000);
      for (int k = 1; k <= 1124; k++) begin
         tick();
         chk($sformatf("ramp k=%0d", k), {21'd0, wrap, phase},
             {21'd0, ((k % 1024) == 0) ? 1'b1 : 1'b0, 10'(k % 1024)});
      end

      // Deferred word: steps stay +1 until the wrap, then +2.
      drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0080_0000, 10'h000);
      tick();
      chk_all("defer accept", 10'd101, 1'b0, 1'b0, 32'h0040_0000);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 10'h000);
      for (int j = 102; j <= 1024; j++) begin
         if (j == 150) ftw_valid = 1'b0;
         tick();
         if (j == 1024) begin
            chk_all("defer wrap", 10'h000, 1'b1, 1'b1, 32'h0080_0000);
         end else begin
            chk($sformatf("pending j=%0d", j), {20'd0, ftw_ready, wrap, phase}, {20'd0, 1'b0, 1'b0, 10'(j)});
         end
      end
      tick();
      chk_all("after wrap 1", 10'd2, 1'b0, 1'b1, 32'h0080_0000);
      tick();
      chk_all("after wrap 2", 10'd4, 1'b0, 1'b1, 32'h0080_0000);

      // Clear while pending releases the shadow; clear with handshake applies at once.
      drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h00C0_0000, 10'h000);
      tick();
      chk_all("pend2 accept", 10'd6, 1'b0, 1'b0, 32'h0080_0000);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 10'h000);
      tick();
      tick();
      chk_all("pend2 run", 10'd10, 1'b0, 1'b0, 32'h0080_0000);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 10'h123);
      tick();
      chk_all("clear pending", 10'h123, 1'b0, 1'b1, 32'h00C0_0000);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0100_0000, 10'h123);
      tick();
      chk_all("clear+handshake", 10'h123, 1'b0, 1'b1, 32'h0100_0000);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 10'h000);
      tick();
      chk_all("post clear step", 10'd4, 1'b0, 1'b1, 32'h0100_0000);

      // Asynchronous reset while pending discards the shadow.
      drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0200_0000, 10'h000);
      tick();
      chk_all("pend3 accept", 10'd8, 1'b0, 1'b0, 32'h0100_0000);
      ftw_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async reset", 10'h000, 1'b0, 1'b1, 32'h0000_0000);
      #2;
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 10'h000);
      tick();
      chk_all("post reset 1", 10'h000, 1'b0, 1'b1, 32'h8000_0000);
      ftw_valid = 1'b0;
      tick();
      chk_all("post reset 2", 10'h200, 1'b0, 1'b1, 32'h8000_0000);
      tick();
      chk_all("post reset 3", 10'h000, 1'b1, 1'b1, 32'h8000_0000);
      tick();
      chk_all("post reset 4", 10'h200, 1'b0, 1'b1, 32'h8000_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
